// File: rtl/result_collector.sv
// result_collector
//
// Captures each completed result from the three-slot processing stage on the
// falling edge of its busy signal, tags it with a rotating slot number
// (0,1,2) and buffers {tag, data} in a small FIFO that has a valid/ready
// output. A sticky overflow flag records any result dropped because the FIFO
// was full.
//
// Optional feature: define RESULT_COLLECTOR_CHECKSUM_EN to build a running
// modulo-2^BW sum of accepted results. Without the macro, checksum is tied
// to 0. The port list is the same in both builds.
//
// Parameters:
//   BW     result data width
//   DEPTH  FIFO entries (power of two, >= 2)
//   AW     pointer width, derived from DEPTH
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   busy_in    upstream busy
//   data_in    upstream data_out, sampled in the cycle busy falls
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts the head entry
//   out_data   head entry data (don't-care while out_valid is 0)
//   out_tag    head entry slot tag
//   count      entries held
//   full       count == DEPTH
//   overflow   sticky, set when a result is dropped
//   checksum   running sum of accepted results (0 when feature disabled)
module result_collector #(
  parameter  int BW    = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          busy_in,
  input  logic [BW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic [1:0]    out_tag,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic [BW-1:0] checksum
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic          busy_d;
  logic [1:0]    slot;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [BW+1:0] mem [DEPTH];

  logic done_evt;
  logic pop;
  logic push;
  logic drop;

  // Event detect: a completion is busy high last cycle and low now. The
  // result data is valid in this same cycle.
  assign done_evt = busy_d & ~busy_in;
  assign pop      = out_valid & out_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // can still accept.
  assign push     = done_evt & (~full | pop);
  assign drop     = done_evt & full & ~pop;

  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign out_valid = (count_q != '0);
  assign overflow  = overflow_q;
  assign out_tag   = mem[rd_ptr][BW+1:BW];
  assign out_data  = mem[rd_ptr][BW-1:0];

  // FIFO control state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_d     <= 1'b0;
      slot       <= 2'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      busy_d <= busy_in;
      // Slot advances on every event, accepted or dropped, so a drop
      // shows up downstream as a tag gap.
      if (done_evt)
        slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;
      if (drop)
        overflow_q <= 1'b1;
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= {slot, data_in};
  end

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  logic [BW-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst)
      sum_q <= '0;
    else if (push)
      sum_q <= sum_q + data_in;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

  logic       clk;
  logic       rst;
  logic       busy_in;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [9:0] q[$];
  logic [1:0] m_slot;
  logic       m_busy_d;
  logic       m_ovf;
  logic [7:0] m_sum;

  result_collector #(.BW(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .busy_in(busy_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .count(count), .full(full), .overflow(overflow),
    .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus. Expected entries are pushed when an event
  // is driven and popped/compared when the DUT hands an entry out.
  task automatic drive_cycle(input logic b, input logic [7:0] d, input logic rdy);
    logic ev, pop, fullm;
    logic [9:0] head;
    busy_in = b;
    data_in = d;
    out_ready = rdy;
    ev = m_busy_d && !b;
    pop = rdy && (q.size() > 0);
    fullm = (q.size() == 8);
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid got %b want %b", out_valid, (q.size() != 0));
    end
    if (pop) begin
      head = q.pop_front();
      checks++;
      if ({out_tag, out_data} !== head) begin
        errors++;
        $display("FAIL pop_entry got tag %0d data %h want tag %0d data %h",
                 out_tag, out_data, head[9:8], head[7:0]);
      end
    end
    if (ev) begin
      if (!fullm || pop) begin
        q.push_back({m_slot, d});
        m_sum = m_sum + d;
      end else begin
        m_ovf = 1'b1;
      end
      m_slot = (m_slot == 2'd2) ? 2'd0 : m_slot + 2'd1;
    end
    m_busy_d = b;
    @(posedge clk); #1;
    checks++;
    if (count !== 4'(q.size())) begin
      errors++;
      $display("FAIL count got %0d want %0d", count, q.size());
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow got %b want %b", overflow, m_ovf);
    end
  endtask

  task automatic do_event(input logic [7:0] d, input logic rdy);
    drive_cycle(1'b1, 8'h00, rdy);
    drive_cycle(1'b0, d, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    busy_in = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_slot = 2'd0;
    m_busy_d = 1'b0;
    m_ovf = 1'b0;
    m_sum = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || full !== 1'b0 ||
        overflow !== 1'b0 || checksum !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got v%b c%0d f%b o%b s%h want all zero",
               out_valid, count, full, overflow, checksum);
    end
  endtask

  task automatic test_single_capture();
    do_reset();
    do_event(8'h11, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_tag !== 2'd0 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_capture got v%b d%h t%0d c%0d want v1 d11 t0 c1",
               out_valid, out_data, out_tag, count);
    end
  endtask

  task automatic test_drain_order();
    logic [7:0] exp_d;
    do_reset();
    do_event(8'h11, 1'b0);
    do_event(8'h21, 1'b0);
    do_event(8'h31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_d = 8'h11 + 8'(i * 16);
      checks++;
      if (out_tag !== 2'(i) || out_data !== exp_d) begin
        errors++;
        $display("FAIL drain_order got t%0d d%h want t%0d d%h", out_tag, out_data, i, exp_d);
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got c%0d v%b want c0 v0", count, out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_event(8'h40 + 8'(i), 1'b0);
      if (i == 7) begin
        checks++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL full_after_8 got %b want 1", full);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL overflow_9th got o%b c%0d want o1 c8", overflow, count);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_tag !== 2'(i % 3)) begin
        errors++;
        $display("FAIL ovf_tag_seq got %0d want %0d", out_tag, i % 3);
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
    do_event(8'h5A, 1'b0);
    checks++;
    if (out_tag !== 2'd0 || out_data !== 8'h5A) begin
      errors++;
      $display("FAIL tag_after_drop got t%0d d%h want t0 d5a", out_tag, out_data);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 8; i++) do_event(8'h60 + 8'(i), 1'b0);
    drive_cycle(1'b1, 8'h00, 1'b0);
    drive_cycle(1'b0, 8'hA5, 1'b1);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop got c%0d o%b f%b want c8 o0 f1", count, overflow, full);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++;
        if (out_data !== 8'hA5) begin
          errors++;
          $display("FAIL full_pushpop_last got %h want a5", out_data);
        end
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_checksum();
    logic [7:0] exp_sum;
    do_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'h00, 1'b0);
    drive_cycle(1'b0, 8'hFE, 1'b0);
    drive_cycle(1'b0, 8'hFE, 1'b0);
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL one_per_edge got %0d want 1", count);
    end
    do_event(8'h03, 1'b0);
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    exp_sum = 8'h01;
`else
    exp_sum = 8'h00;
`endif
    checks++;
    if (checksum !== exp_sum || count !== 4'd2) begin
      errors++;
      $display("FAIL checksum got s%h c%0d want s%h c2", checksum, count, exp_sum);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 9; i++) do_event(8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b1, 8'h00, 1'b1);
    checks++;
    if (count !== 4'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got c%0d o%b want c2 o1", count, overflow);
    end
    drive_cycle(1'b1, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'h00, 1'b0);
    // bring count to 3 held, then reset while busy falls
    drive_cycle(1'b0, 8'h90, 1'b0);
    drive_cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL held_3 got %0d want 3", count);
    end
    data_in = 8'h77;
    do_reset();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got c%0d v%b o%b want c0 v0 o0", count, out_valid, overflow);
    end
    do_event(8'h99, 1'b0);
    checks++;
    if (out_tag !== 2'd0 || out_data !== 8'h99 || count !== 4'd1) begin
      errors++;
      $display("FAIL tag_after_reset got t%0d d%h c%0d want t0 d99 c1", out_tag, out_data, count);
    end
  endtask

  initial begin
    rst = 1'b1;
    busy_in = 1'b0;
    data_in = 8'h00;
    out_ready = 1'b0;
    m_slot = 2'd0;
    m_busy_d = 1'b0;
    m_ovf = 1'b0;
    m_sum = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_single_capture();
    test_drain_order();
    test_overflow();
    test_full_pushpop();
    test_checksum();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
